systolic_array: RTL and testbench

Min-priority queue of `QUEUE_SIZE` entries built as a linear systolic array of compare cells. Each cell talks only to its neighbours. The block accepts enqueue, dequeue and replace (pop-min plus insert) operations. It always presents the current minimum on `o_data` one clock after the operation is issued. It is the queue core for scheduler/sorter datapaths that need O(1) access to the smallest key.

---
 rtl/systolic_array.sv | 155 +++++++++++++++
 tb/tb_systolic_array.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array.sv
// Min-priority queue built as a linear systolic array of compare cells.
// Cell 0 always holds the minimum; insert/replace tokens ripple one cell per cycle.
module systolic_array #(
    parameter int unsigned QUEUE_SIZE = 8,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_wrt,
    input  logic                  i_read,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int unsigned CW = $clog2(QUEUE_SIZE + 1);
    localparam int unsigned KW = DATA_WIDTH + 1;
    localparam logic [DATA_WIDTH-1:0] KEY_EMPTY = '1;
    localparam logic [CW-1:0] COUNT_MAX = CW'(QUEUE_SIZE);
    localparam logic TK_INSERT = 1'b0;
    localparam logic TK_REPLACE = 1'b1;

    // cell storage
    logic [DATA_WIDTH-1:0] key_q [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] key_d [QUEUE_SIZE];
    logic [QUEUE_SIZE-1:0] vld_q, vld_d;

    // token registers; entry j feeds cell j+1
    logic                  tok_v_q [QUEUE_SIZE-1];
    logic                  tok_k_q [QUEUE_SIZE-1];
    logic                  tok_e_q [QUEUE_SIZE-1];
    logic [DATA_WIDTH-1:0] tok_x_q [QUEUE_SIZE-1];
    logic                  tok_v_d [QUEUE_SIZE-1];
    logic                  tok_k_d [QUEUE_SIZE-1];
    logic                  tok_e_d [QUEUE_SIZE-1];
    logic [DATA_WIDTH-1:0] tok_x_d [QUEUE_SIZE-1];

    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, blocked_q;
    logic          op_ins_c, op_deq_c, op_rep_c, accept_c;

    // token seen by each cell this cycle, and what it hands to its neighbour
    logic                  in_v [QUEUE_SIZE];
    logic                  in_k [QUEUE_SIZE];
    logic                  in_e [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] in_x [QUEUE_SIZE];
    logic                  fwd_v [QUEUE_SIZE];
    logic [DATA_WIDTH-1:0] fwd_x [QUEUE_SIZE];
    logic [KW-1:0]         nxt_ext [QUEUE_SIZE];

    // port decode; replace on an empty queue degenerates to an enqueue
    always_comb begin
        op_ins_c = 1'b0;
        op_deq_c = 1'b0;
        op_rep_c = 1'b0;
        if (!blocked_q) begin
            op_ins_c = i_wrt & ((~i_read & ~full_q) | (i_read & empty_q));
            op_deq_c = ~i_wrt & i_read & ~empty_q;
            op_rep_c = i_wrt & i_read & ~empty_q;
        end
        accept_c = op_ins_c | op_deq_c | op_rep_c;
        count_d  = count_q;
        if (op_ins_c) count_d = count_q + CW'(1);
        else if (op_deq_c) count_d = count_q - CW'(1);
    end

    always_comb begin
        in_v[0] = op_ins_c | op_deq_c | op_rep_c;
        in_k[0] = op_ins_c ? TK_INSERT : TK_REPLACE;
        in_e[0] = op_deq_c;
        in_x[0] = op_deq_c ? KEY_EMPTY : i_data;
        for (int i = 1; i < QUEUE_SIZE; i++) begin
            in_v[i] = tok_v_q[i-1];
            in_k[i] = tok_k_q[i-1];
            in_e[i] = tok_e_q[i-1];
            in_x[i] = tok_x_q[i-1];
        end
        // empty cells compare as +infinity: {empty, key} with empty as MSB
        for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
            nxt_ext[i] = {~vld_q[i+1], key_q[i+1]};
        end
        nxt_ext[QUEUE_SIZE-1] = {1'b1, KEY_EMPTY};
    end

    // per-cell compare/swap rules
    always_comb begin
        key_d = key_q;
        vld_d = vld_q;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            fwd_v[i] = 1'b0;
            fwd_x[i] = in_x[i];
            if (in_v[i]) begin
                if (in_k[i] == TK_INSERT) begin
                    if (!vld_q[i]) begin
                        key_d[i] = in_x[i];
                        vld_d[i] = 1'b1;
                    end else begin
                        fwd_v[i] = 1'b1;
                        if (in_x[i] < key_q[i]) begin
                            key_d[i] = in_x[i];
                            fwd_x[i] = key_q[i];
                        end
                    end
                end else if ({in_e[i], in_x[i]} <= nxt_ext[i]) begin
                    key_d[i] = in_e[i] ? KEY_EMPTY : in_x[i];
                    vld_d[i] = ~in_e[i];
                end else begin
                    key_d[i] = nxt_ext[i][DATA_WIDTH-1:0];
                    vld_d[i] = ~nxt_ext[i][DATA_WIDTH];
                    fwd_v[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
            tok_v_d[i] = fwd_v[i];
            tok_k_d[i] = in_k[i];
            tok_e_d[i] = in_e[i];
            tok_x_d[i] = fwd_x[i];
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            for (int i = 0; i < QUEUE_SIZE; i++) key_q[i] <= KEY_EMPTY;
            vld_q <= '0;
            for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
                tok_v_q[i] <= 1'b0;
                tok_k_q[i] <= TK_INSERT;
                tok_e_q[i] <= 1'b0;
                tok_x_q[i] <= KEY_EMPTY;
            end
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            blocked_q <= 1'b0;
        end else begin
            key_q     <= key_d;
            vld_q     <= vld_d;
            tok_v_q   <= tok_v_d;
            tok_k_q   <= tok_k_d;
            tok_e_q   <= tok_e_d;
            tok_x_q   <= tok_x_d;
            count_q   <= count_d;
            full_q    <= (count_d == COUNT_MAX);
            empty_q   <= (count_d == '0);
            blocked_q <= accept_c;
        end
    end

    assign o_data  = key_q[0];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: sorted-queue reference model checked every
// cycle, plus hand-computed expectations at each step.
module tb_systolic_array;

    localparam int unsigned N = 8;
    localparam int unsigned W = 16;

    logic         clk;
    logic         rst_n;
    logic         wrt;
    logic         rd;
    logic [W-1:0] din;
    logic         full;
    logic         empty;
    logic [W-1:0] dout;

    int total = 0;
    int bad   = 0;

    int mq[$];
    bit mblk;
    bit macc;

    systolic_array #(.QUEUE_SIZE(N), .DATA_WIDTH(W)) dut (
        .i_CLK  (clk),
        .i_RSTn (rst_n),
        .i_wrt  (wrt),
        .i_read (rd),
        .i_data (din),
        .o_full (full),
        .o_empty(empty),
        .o_data (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: a plain sorted list of keys plus the issue-spacing rule
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mblk = 1'b0;
        end else begin
            macc = 1'b0;
            if (!mblk) begin
                if (wrt && !rd && mq.size() < N) begin
                    mq.push_back(int'(din));
                    macc = 1'b1;
                end else if (!wrt && rd && mq.size() > 0) begin
                    void'(mq.pop_front());
                    macc = 1'b1;
                end else if (wrt && rd) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    mq.push_back(int'(din));
                    macc = 1'b1;
                end
                mq.sort();
            end
            mblk = macc;
        end
    end

    function automatic logic [W-1:0] model_min();
        return (mq.size() > 0) ? W'(mq[0]) : '1;
    endfunction

    always @(negedge clk) begin
        total++;
        if (dout !== model_min() || full !== (mq.size() == N) || empty !== (mq.size() == 0)) begin
            bad++;
            $display("FAIL model t=%0t got data=%0h full=%b empty=%b exp data=%0h full=%b empty=%b",
                     $time, dout, full, empty, model_min(), mq.size() == N, mq.size() == 0);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic op(input bit w, input bit r, input int d);
        wrt = w;
        rd  = r;
        din = W'(d);
        @(negedge clk);
        wrt = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int ev[8] = '{500, 20, 900, 7, 1024, 300, 7, 64};
    int em[8] = '{500, 20, 20, 7, 7, 7, 7, 7};
    int dm[8] = '{7, 20, 64, 300, 500, 900, 1024, 'hFFFF};
    int fv[8] = '{30, 30, 10, 50, 20, 60, 40, 70};
    int fd[8] = '{30, 30, 40, 50, 60, 70, 80, 'hFFFF};

    initial begin
        rst_n = 1'b0;
        wrt   = 1'b0;
        rd    = 1'b0;
        din   = '0;
        idle(3);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_data", 32'(dout), 'hFFFF);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) begin
            op(1, 0, ev[i]);
            chk($sformatf("enq%0d", i), 32'(dout), 32'(em[i]));
            idle(2);
        end
        chk("full_after_8", 32'(full), 1);

        op(1, 0, 1);
        chk("enq_full_data", 32'(dout), 7);
        chk("enq_full_flag", 32'(full), 1);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            op(0, 1, 0);
            chk($sformatf("deq%0d", i), 32'(dout), 32'(dm[i]));
            idle(3);
        end
        chk("empty_after_drain", 32'(empty), 1);
        op(0, 1, 0);
        chk("deq_empty_data", 32'(dout), 'hFFFF);
        chk("deq_empty_flag", 32'(empty), 1);
        idle(2);

        op(1, 0, 10); idle(2);
        op(1, 0, 40); idle(2);
        op(1, 0, 70); idle(2);
        op(1, 1, 50);
        chk("rep50", 32'(dout), 40);
        idle(3);
        op(1, 1, 5);
        chk("rep5", 32'(dout), 5);
        idle(3);
        op(0, 1, 0); chk("rep_drain0", 32'(dout), 50); idle(3);
        op(0, 1, 0); chk("rep_drain1", 32'(dout), 70); idle(3);
        op(0, 1, 0); chk("rep_drain2", 32'(dout), 'hFFFF); idle(3);
        op(1, 1, 3);
        chk("rep_on_empty_data", 32'(dout), 3);
        chk("rep_on_empty_flag", 32'(empty), 0);
        idle(3);
        op(0, 1, 0);
        chk("rep_on_empty_pop", 32'(dout), 'hFFFF);
        idle(2);

        op(1, 0, 9); chk("fast_enq9", 32'(dout), 9); idle(1);
        op(1, 0, 4); chk("fast_enq4", 32'(dout), 4); idle(1);
        op(1, 0, 6); chk("fast_enq6", 32'(dout), 4); idle(1);
        op(0, 1, 0); chk("fast_deq", 32'(dout), 6); idle(1);
        op(1, 0, 8); chk("fast_enq8", 32'(dout), 6);
        op(1, 0, 2); chk("dropped_enq2", 32'(dout), 6); idle(1);
        op(0, 1, 0); chk("fast_pop8", 32'(dout), 8); idle(1);
        op(0, 1, 0); chk("fast_pop9", 32'(dout), 9); idle(1);
        op(0, 1, 0); chk("fast_pop_empty", 32'(dout), 'hFFFF); idle(1);

        for (int i = 0; i < 8; i++) begin
            op(1, 0, fv[i]);
            idle(1);
        end
        chk("full_refill", 32'(full), 1);
        op(1, 1, 25);
        chk("rep_full25", 32'(dout), 20);
        chk("rep_full_flag", 32'(full), 1);
        idle(1);
        op(1, 1, 80);
        chk("rep_full80", 32'(dout), 25);
        idle(1);
        for (int i = 0; i < 8; i++) begin
            op(0, 1, 0);
            chk($sformatf("full_drain%0d", i), 32'(dout), 32'(fd[i]));
            idle(1);
        end

        op(1, 0, 3); idle(1);
        op(1, 0, 2); idle(1);
        op(1, 0, 1); idle(1);
        wrt = 1'b1;
        din = '0;
        @(posedge clk);
        #1 wrt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_full", 32'(full), 0);
        chk("midrst_data", 32'(dout), 'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        op(1, 0, 12);
        chk("post_rst_enq", 32'(dout), 12);
        idle(N + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
